// File: rtl/neuron_pkg.sv
// Shared types and fixed-point helper for the sequential neuron MAC.
// fx_mul covers DATA_W up to 63 and ACC_W up to 128.
package neuron_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_FRAC_W = 16;
  localparam int DEF_ACC_W  = 64;
  localparam logic [31:0] DEF_BIAS_IN = 32'h0001_0000;

  localparam int FX_W   = 64;
  localparam int FX_P_W = 2 * FX_W;

  // Operands arrive already sign-extended to FX_W, so the full-width product is exact
  // and >>> gives floor rounding of the fractional bits.
  function automatic logic signed [FX_P_W-1:0] fx_mul(input logic signed [FX_W-1:0] x,
                                                      input logic signed [FX_W-1:0] w,
                                                      input int frac);
    logic signed [FX_P_W-1:0] xe;
    logic signed [FX_P_W-1:0] we;
    logic signed [FX_P_W-1:0] p;
    xe = {{FX_W{x[FX_W-1]}}, x};
    we = {{FX_W{w[FX_W-1]}}, w};
    p  = xe * we;
    return p >>> frac;
  endfunction

endpackage

// File: rtl/neuron_mac_lane.sv
// One combinational fixed-point product lane; a disabled lane contributes zero.
module neuron_mac_lane
  import neuron_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int FRAC_W = DEF_FRAC_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] w,
  input  logic              en,
  output logic [ACC_W-1:0]  term
);

  logic signed [FX_W-1:0] xe;
  logic signed [FX_W-1:0] we;
  logic [ACC_W-1:0]       prod;

  assign xe   = {{(FX_W-DATA_W){x[DATA_W-1]}}, x};
  assign we   = {{(FX_W-DATA_W){w[DATA_W-1]}}, w};
  assign prod = ACC_W'(fx_mul(xe, we, FRAC_W));
  assign term = en ? prod : '0;

endmodule

// File: rtl/neuron_mac_seq.sv
// Time-multiplexed neuron dot product with bias term, LANES products per cycle.
// Optional output clamping is enabled by defining NEURON_MAC_SAT_EN.
module neuron_mac_seq
  import neuron_pkg::*;
#(
  parameter int N_INPUTS = 32,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int FRAC_W   = DEF_FRAC_W,
  parameter int LANES    = 4,
  parameter int ACC_W    = DEF_ACC_W,
  parameter logic [DATA_W-1:0] BIAS_IN = DATA_W'(DEF_BIAS_IN)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [N_INPUTS-1:0][DATA_W-1:0]  in_data,
  input  logic [N_INPUTS:0][DATA_W-1:0]    in_weight,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DATA_W-1:0]                out_sum,
  output logic                             out_sat
);

  localparam int N_TERMS = N_INPUTS + 1;
  localparam int IDX_W   = $clog2(N_TERMS + LANES);

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  state_e state;
  state_e next_state;

  logic [N_TERMS-1:0][DATA_W-1:0] x_q;
  logic [N_TERMS-1:0][DATA_W-1:0] w_q;
  logic [IDX_W-1:0]               idx;
  logic [ACC_W-1:0]               acc;

  logic [DATA_W-1:0] x_sel [LANES];
  logic [DATA_W-1:0] w_sel [LANES];
  logic              lane_en [LANES];
  logic [ACC_W-1:0]  lane_term [LANES];
  logic [ACC_W-1:0]  group_sum;
  logic [ACC_W-1:0]  acc_next;
  logic              last_group;
  logic [DATA_W-1:0] sum_final;
  logic              sat_final;

  // Lane l works on term idx+l; lanes beyond the last term are disabled.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      x_sel[l]   = '0;
      w_sel[l]   = '0;
      lane_en[l] = (int'(idx) + l) < N_TERMS;
      for (int j = 0; j < N_TERMS; j++) begin
        if ((int'(idx) + l) == j) begin
          x_sel[l] = x_q[j];
          w_sel[l] = w_q[j];
        end
      end
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    neuron_mac_lane #(
      .DATA_W (DATA_W),
      .FRAC_W (FRAC_W),
      .ACC_W  (ACC_W)
    ) u_lane (
      .x    (x_sel[g]),
      .w    (w_sel[g]),
      .en   (lane_en[g]),
      .term (lane_term[g])
    );
  end

  always_comb begin
    group_sum = '0;
    for (int l = 0; l < LANES; l++) begin
      group_sum = group_sum + lane_term[l];
    end
    acc_next   = acc + group_sum;
    last_group = (int'(idx) + LANES) >= N_TERMS;
  end

  always_comb begin
    sum_final = acc_next[DATA_W-1:0];
    sat_final = 1'b0;
`ifdef NEURON_MAC_SAT_EN
    if ($signed(acc_next) > SAT_MAX) begin
      sum_final = SAT_MAX[DATA_W-1:0];
      sat_final = 1'b1;
    end else if ($signed(acc_next) < SAT_MIN) begin
      sum_final = SAT_MIN[DATA_W-1:0];
      sat_final = 1'b1;
    end
`else
    sat_final = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) next_state = RUN;
      end
      RUN: begin
        if (last_group) next_state = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Operands are captured once at accept; the bias input is folded in as the last x entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q     <= '0;
      w_q     <= '0;
      idx     <= '0;
      acc     <= '0;
      out_sum <= '0;
      out_sat <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            x_q <= {BIAS_IN, in_data};
            w_q <= in_weight;
            acc <= '0;
            idx <= '0;
          end
        end
        RUN: begin
          acc <= acc_next;
          idx <= idx + IDX_W'(LANES);
          if (last_group) begin
            out_sum <= sum_final;
            out_sat <= sat_final;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_mac_seq.sv
// Directed bench for neuron_mac_seq: N_INPUTS=4, Q16.16, LANES 2 (main), 1 and 5.
// Expectations for the large-product case follow NEURON_MAC_SAT_EN.
module tb_neuron_mac_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic              out_ready;
  logic [3:0][31:0]  in_data;
  logic [4:0][31:0]  in_weight;
  logic              in_valid_v  [3];
  logic              in_ready_v  [3];
  logic              out_valid_v [3];
  logic [31:0]       out_sum_v   [3];
  logic              out_sat_v   [3];

  int total = 0;
  int bad   = 0;

  neuron_mac_seq #(.N_INPUTS(4), .LANES(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .in_data(in_data), .in_weight(in_weight), .out_valid(out_valid_v[0]),
    .out_ready(out_ready), .out_sum(out_sum_v[0]), .out_sat(out_sat_v[0])
  );

  neuron_mac_seq #(.N_INPUTS(4), .LANES(1)) dut_l1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .in_data(in_data), .in_weight(in_weight), .out_valid(out_valid_v[1]),
    .out_ready(out_ready), .out_sum(out_sum_v[1]), .out_sat(out_sat_v[1])
  );

  neuron_mac_seq #(.N_INPUTS(4), .LANES(5)) dut_l5 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
    .in_data(in_data), .in_weight(in_weight), .out_valid(out_valid_v[2]),
    .out_ready(out_ready), .out_sum(out_sum_v[2]), .out_sat(out_sat_v[2])
  );

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic fill(input logic [31:0] xv, input logic [31:0] wv, input logic [31:0] bw);
    for (int i = 0; i < 4; i++) begin
      in_data[i]   = xv;
      in_weight[i] = wv;
    end
    in_weight[4] = bw;
  endtask

  // Accept on one edge, count edges until out_valid, then hand the result off.
  task automatic apply_stimulus(input int d, input int k_exp, input logic [31:0] exp_sum,
                                input logic exp_sat, input string tag);
    int cnt;
    check_output({tag, "_ready"}, 64'(in_ready_v[d]), 64'd1);
    in_valid_v[d] = 1'b1;
    @(posedge clk);
    #1;
    in_valid_v[d] = 1'b0;
    cnt = 0;
    while (!out_valid_v[d] && cnt < 20) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check_output({tag, "_lat"}, 64'(cnt), 64'(k_exp));
    check_output({tag, "_sum"}, 64'(out_sum_v[d]), 64'(exp_sum));
    check_output({tag, "_sat"}, 64'(out_sat_v[d]), 64'(exp_sat));
    @(posedge clk);
    #1;
    check_output({tag, "_vclr"}, 64'(out_valid_v[d]), 64'd0);
    check_output({tag, "_idle"}, 64'(in_ready_v[d]), 64'd1);
  endtask

  initial begin
    int cnt;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) in_valid_v[i] = 1'b0;
    fill(32'h0, 32'h0, 32'h0);
    #2 rst_n = 1'b0;
    #10;
    check_output("rst_valid", 64'(out_valid_v[0]), 64'd0);
    check_output("rst_sum",   64'(out_sum_v[0]),   64'd0);
    check_output("rst_sat",   64'(out_sat_v[0]),   64'd0);
    check_output("rst_ready", 64'(in_ready_v[0]),  64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] all-ones");
    fill(32'h0001_0000, 32'h0001_0000, 32'h0001_0000);
    apply_stimulus(0, 3, 32'h0005_0000, 1'b0, "t1");

    $display("[TB] negative times half");
    fill(32'h0, 32'h0, 32'h0);
    in_data[0]   = 32'hFFFE_0000;
    in_weight[0] = 32'h0000_8000;
    apply_stimulus(0, 3, 32'hFFFF_0000, 1'b0, "t2");

    $display("[TB] floor rounding");
    in_data[0] = 32'hFFFF_FFFF;
    apply_stimulus(0, 3, 32'hFFFF_FFFF, 1'b0, "floor");

    $display("[TB] bias only");
    fill(32'h0, 32'h0, 32'h0002_0000);
    apply_stimulus(0, 3, 32'h0002_0000, 1'b0, "bias");

    $display("[TB] mixed signs");
    in_data[0] = 32'h0001_0000; in_weight[0] = 32'h0002_0000;
    in_data[1] = 32'h0002_0000; in_weight[1] = 32'hFFFE_8000;
    in_data[2] = 32'hFFFD_0000; in_weight[2] = 32'h0000_8000;
    in_data[3] = 32'h0000_4000; in_weight[3] = 32'h0004_0000;
    in_weight[4] = 32'hFFFF_4000;
    apply_stimulus(0, 3, 32'hFFFD_C000, 1'b0, "mixed");

    $display("[TB] large products");
    fill(32'h7FFF_0000, 32'h7FFF_0000, 32'h0);
`ifdef NEURON_MAC_SAT_EN
    apply_stimulus(0, 3, 32'h7FFF_FFFF, 1'b1, "t3");
`else
    apply_stimulus(0, 3, 32'h0004_0000, 1'b0, "t3");
`endif

    $display("[TB] output backpressure");
    fill(32'h0001_0000, 32'h0001_0000, 32'h0001_0000);
    out_ready     = 1'b0;
    in_valid_v[0] = 1'b1;
    @(posedge clk);
    #1;
    in_valid_v[0] = 1'b0;
    cnt = 0;
    while (!out_valid_v[0] && cnt < 20) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check_output("t4_lat", 64'(cnt), 64'd3);
    fill(32'h0002_0000, 32'h0002_0000, 32'h0002_0000);
    in_valid_v[0] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check_output("t4_hold_sum",   64'(out_sum_v[0]),   64'h0005_0000);
      check_output("t4_hold_valid", 64'(out_valid_v[0]), 64'd1);
      check_output("t4_hold_ready", 64'(in_ready_v[0]),  64'd0);
    end
    in_valid_v[0] = 1'b0;
    out_ready     = 1'b1;
    @(posedge clk);
    #1;
    check_output("t4_vclr", 64'(out_valid_v[0]), 64'd0);
    check_output("t4_idle", 64'(in_ready_v[0]),  64'd1);
    check_output("t4_keep", 64'(out_sum_v[0]),   64'h0005_0000);

    $display("[TB] reset during run");
    fill(32'h0003_0000, 32'h0003_0000, 32'h0003_0000);
    in_valid_v[0] = 1'b1;
    @(posedge clk);
    #1;
    in_valid_v[0] = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("t5_valid", 64'(out_valid_v[0]), 64'd0);
    check_output("t5_ready", 64'(in_ready_v[0]),  64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    fill(32'h0001_0000, 32'h0001_0000, 32'h0001_0000);
    apply_stimulus(0, 3, 32'h0005_0000, 1'b0, "t5_rerun");

    $display("[TB] lane count variants");
    apply_stimulus(1, 5, 32'h0005_0000, 1'b0, "t6_l1");
    apply_stimulus(2, 1, 32'h0005_0000, 1'b0, "t6_l5");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
